// File: rtl/uarch_clr_sequencer_pkg.sv
// Shared definitions for the microarchitectural clear sequencer.
// Holds the sequencer state encoding, the default clear and settle lengths
// (so the flush controller and the sequencer agree), and a counter-width helper.
package uarch_clr_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        CLEAR  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } uarch_clr_state_e;

    localparam int UARCH_CLR_CYCLES = 16;
    localparam int UARCH_CLR_SETTLE = 4;

    // Width needed to hold 0..max_count, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/uarch_clr_next_idx.sv
// Next-set-bit search.
// Returns the lowest set bit of mask_i strictly above cur_i.
//   mask_i  : domain mask to search
//   cur_i   : current domain index
//   nxt_o   : lowest set index above cur_i (0 when none)
//   valid_o : a set bit above cur_i exists
module uarch_clr_next_idx #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] cur_i,
    output logic [IW-1:0] nxt_o,
    output logic          valid_o
);

    // Priority search from low to high; the first hit locks out later ones.
    always_comb begin
        logic hit;
        nxt_o   = '0;
        valid_o = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit     = mask_i[i] & (i > int'(cur_i)) & ~valid_o;
            nxt_o   = hit ? IW'(i) : nxt_o;
            valid_o = valid_o | hit;
        end
    end

endmodule

// File: rtl/uarch_clr_sequencer.sv
// Microarchitectural clear sequencer run after fence.t.
// On start it waits for the selected domains to drain, pulses each selected
// domain's clear for CLR_CYCLES in ascending order, settles, then signals done.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : start request (accepted only in IDLE)
//   clr_mask_i     : domains to clear, captured with start_i
//   domain_idle_i  : per-domain drained indication
//   pad_zero_i     : fence.t pad counter expired
//   clr_o          : one-hot per-domain clear
//   busy_o         : sequence in progress
//   done_o         : one-cycle completion pulse
//   timeout_o      : sticky, last drain ended by timeout
//   overrun_o      : start_i seen while busy (request dropped)
module uarch_clr_sequencer
    import uarch_clr_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int CLR_CYCLES    = UARCH_CLR_CYCLES,
    parameter int SETTLE_CYCLES = UARCH_CLR_SETTLE,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [NUM_DOMAINS-1:0] clr_mask_i,
    input  logic [NUM_DOMAINS-1:0] domain_idle_i,
    input  logic                   pad_zero_i,
    output logic [NUM_DOMAINS-1:0] clr_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic                   overrun_o
);

    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int DW = cnt_width(DRAIN_TIMEOUT);
    localparam int CW = cnt_width(CLR_CYCLES);
    localparam int SW = cnt_width(SETTLE_CYCLES);

    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    // A zero-length settle skips SETTLE entirely.
    localparam uarch_clr_state_e AFTER_CLEAR = (SETTLE_CYCLES > 0) ? SETTLE : DONE;

    uarch_clr_state_e       state_q, state_d;
    logic [NUM_DOMAINS-1:0] mask_q, mask_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]          clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
    logic                   timeout_q, timeout_d;

    logic [IW-1:0]          nxt_idx_s;
    logic                   nxt_valid_s;
    logic                   ready_s;
    logic                   timeout_now_s;
    logic                   first_valid_s;
    logic [IW-1:0]          first_idx_s;
    logic                   busy_s;

    // idx_q sits at 0 outside CLEAR, so the same search also finds the first
    // domain once bit 0 is handled separately.
    uarch_clr_next_idx #(
        .N  (NUM_DOMAINS),
        .IW (IW)
    ) u_next_idx (
        .mask_i  (mask_q),
        .cur_i   (idx_q),
        .nxt_o   (nxt_idx_s),
        .valid_o (nxt_valid_s)
    );

    // Next-state, counter updates and output decode.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        drain_cnt_d  = drain_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;
        timeout_d    = timeout_q;

        ready_s       = (&(domain_idle_i | ~mask_q)) & pad_zero_i;
        timeout_now_s = (state_q == DRAIN) & ~ready_s & (drain_cnt_q == DRAIN_LAST);
        first_valid_s = mask_q[0] | nxt_valid_s;
        first_idx_s   = mask_q[0] ? '0 : nxt_idx_s;

        case (state_q)
            DRAIN: begin
                if (ready_s || timeout_now_s) begin
                    drain_cnt_d = '0;
                    timeout_d   = timeout_q | timeout_now_s;
                    if (first_valid_s) begin
                        state_d = CLEAR;
                        idx_d   = first_idx_s;
                    end else begin
                        state_d = AFTER_CLEAR;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    if (nxt_valid_s) begin
                        idx_d = nxt_idx_s;
                    end else begin
                        idx_d   = '0;
                        state_d = AFTER_CLEAR;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                mask_d  = '0;
                idx_d   = '0;
            end
            // IDLE and any unknown encoding behave identically.
            default: begin
                if (start_i) begin
                    state_d   = DRAIN;
                    mask_d    = clr_mask_i;
                    timeout_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_s = (state_q == DRAIN) | (state_q == CLEAR) |
                 (state_q == SETTLE) | (state_q == DONE);

        clr_o = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            clr_o[i] = (state_q == CLEAR) & (idx_q == IW'(i));
        end
        busy_o    = busy_s;
        done_o    = (state_q == DONE);
        timeout_o = timeout_q | timeout_now_s;
        overrun_o = busy_s & start_i;
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            drain_cnt_q  <= '0;
            clr_cnt_q    <= '0;
            settle_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            drain_cnt_q  <= drain_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uarch_clr_sequencer.sv
// Directed bench for uarch_clr_sequencer. DUT a uses default parameters,
// DUT b uses DRAIN_TIMEOUT=8 for the timeout case. Cycle 0 is the cycle in
// which start_i is high; inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
module tb_uarch_clr_sequencer;

    logic       clk;
    logic       rst_n;

    logic       a_start, a_pad;
    logic [3:0] a_mask, a_idle, a_clr;
    logic       a_busy, a_done, a_tmo, a_ovr;

    logic       b_start, b_pad;
    logic [3:0] b_mask, b_idle, b_clr;
    logic       b_busy, b_done, b_tmo, b_ovr;

    int n_cmp = 0;
    int n_err = 0;

    uarch_clr_sequencer #(
        .NUM_DOMAINS(4), .CLR_CYCLES(16), .SETTLE_CYCLES(4), .DRAIN_TIMEOUT(1024)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .clr_mask_i(a_mask),
        .domain_idle_i(a_idle), .pad_zero_i(a_pad), .clr_o(a_clr), .busy_o(a_busy),
        .done_o(a_done), .timeout_o(a_tmo), .overrun_o(a_ovr)
    );

    uarch_clr_sequencer #(
        .NUM_DOMAINS(4), .CLR_CYCLES(16), .SETTLE_CYCLES(4), .DRAIN_TIMEOUT(8)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .clr_mask_i(b_mask),
        .domain_idle_i(b_idle), .pad_zero_i(b_pad), .clr_o(b_clr), .busy_o(b_busy),
        .done_o(b_done), .timeout_o(b_tmo), .overrun_o(b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Expected clr_o: the j-th set bit of mask, 16 cycles each, from cycle cs.
    function automatic logic [3:0] exp_clr(input logic [3:0] m, input int c, input int cs);
        logic [3:0] r;
        int j;
        int k;
        r = 4'h0;
        j = (c >= cs) ? (c - cs) / 16 : -1;
        k = 0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                if (k == j) r[b] = 1'b1;
                k++;
            end
        end
        return r;
    endfunction

    // One sequence on DUT a with hand-derived clear start, done cycle and
    // optional second start (overrun) cycle; ovr < 0 means none.
    task automatic run_seq(input string nm, input logic [3:0] mask, input logic [3:0] stall_mask,
                           input int idle_rel, input int pad_rel, input int cs,
                           input int done_c, input int ovr);
        for (int c = 0; c <= done_c + 2; c++) begin
            @(posedge clk); #1;
            a_start = (c == 0) || (c == ovr);
            a_mask  = mask;
            a_idle  = (c < idle_rel) ? ~stall_mask : 4'hF;
            a_pad   = (c >= pad_rel);
            @(negedge clk);
            chk({nm, ".clr"},  c, a_clr, exp_clr(mask, c, cs));
            chk({nm, ".busy"}, c, {3'b000, a_busy}, {3'b000, (c >= 1 && c <= done_c)});
            chk({nm, ".done"}, c, {3'b000, a_done}, {3'b000, (c == done_c)});
            chk({nm, ".ovr"},  c, {3'b000, a_ovr},  {3'b000, (c == ovr && c >= 1 && c <= done_c)});
            chk({nm, ".tmo"},  c, {3'b000, a_tmo},  4'h0);
        end
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_mask = 4'h0; a_idle = 4'hF; a_pad = 1'b1;
        b_start = 1'b0; b_mask = 4'h0; b_idle = 4'hF; b_pad = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.clr",  0, a_clr, 4'h0);
        chk("rst.busy", 0, {3'b000, a_busy}, 4'h0);
        chk("rst.done", 0, {3'b000, a_done}, 4'h0);
        chk("rst.tmo",  0, {3'b000, a_tmo},  4'h0);
        chk("rst.ovr",  0, {3'b000, a_ovr},  4'h0);
        chk("rst.b_clr", 0, b_clr, 4'h0);
        rst_n = 1'b1;

        //       name      mask   stall  idle_rel pad_rel cs  done ovr
        run_seq("basic",  4'hF, 4'h0,  0,       0,      2,  70,  -1);
        run_seq("sparse", 4'h5, 4'h0,  0,       0,      2,  38,  -1);
        run_seq("drain",  4'h2, 4'h2,  40,      0,      41, 61,  -1);
        run_seq("pad",    4'h1, 4'h0,  0,       30,     31, 51,  -1);
        run_seq("empty",  4'h0, 4'h0,  0,       0,      2,  6,   5);

        // Timeout on DUT b: domain 0 stuck busy, then a second start clears the flag.
        for (int c = 0; c <= 36; c++) begin
            @(posedge clk); #1;
            b_start = (c == 0) || (c == 32);
            b_mask  = 4'h1;
            b_idle  = (c < 30) ? 4'hE : 4'hF;
            @(negedge clk);
            chk("tmo.flag", c, {3'b000, b_tmo}, {3'b000, (c >= 8 && c <= 32)});
            chk("tmo.clr",  c, b_clr, ((c >= 9 && c <= 24) || c >= 34) ? 4'h1 : 4'h0);
            chk("tmo.busy", c, {3'b000, b_busy}, {3'b000, ((c >= 1 && c <= 29) || c >= 33)});
            chk("tmo.done", c, {3'b000, b_done}, {3'b000, (c == 29)});
        end
        @(posedge clk); #1;
        b_start = 1'b0;

        // Asynchronous reset in the middle of domain 1's clear.
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1;
            a_start = (c == 0);
            a_mask  = 4'hF;
            a_idle  = 4'hF;
            a_pad   = 1'b1;
            @(negedge clk);
        end
        chk("arst.pre_clr", 20, a_clr, 4'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.clr",  20, a_clr, 4'h0);
        chk("arst.busy", 20, {3'b000, a_busy}, 4'h0);
        chk("arst.done", 20, {3'b000, a_done}, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("after_rst", 4'hF, 4'h0, 0, 0, 2, 70, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
